serial_frame_ctrl: RTL and testbench
====================================

# serial_frame_ctrl

Controller that sequences a WIDTH-bit serial-in shift register into framed parallel words. A start pulse opens a frame; gated bit strobes shift the register; after exactly WIDTH strobes the word moves to a one-entry output buffer with a valid/ready handshake. The block sits between a serial bit source and a parallel consumer, and flags lost words when the consumer falls behind.

## Interface
- WIDTH, 4, frame length in bits; legal range 2..16.

- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous, active-low reset. 0 at a rising edge resets the block.
- start_i  input  1  frame start pulse; honoured only in IDLE.
- en_i  input  1  bit strobe; x_i is sampled only when en_i=1 in SHIFT.
- x_i  input  1  serial data bit.
- ready_i  input  1  consumer accepts word_o when valid_o=1.
- clr_i  input  1  clears ovf_o.
- word_o  output  WIDTH  completed frame; stable while valid_o=1.
- valid_o  output  1  word_o holds an unconsumed frame.
- busy_o  output  1  1 while a frame is being shifted (state SHIFT).
- ovf_o  output  1  sticky overrun flag.

## Operation
- FSM states: IDLE, SHIFT.
  - IDLE: if start_i=1, go to SHIFT, clear the shift register and the bit counter. x_i is not sampled in the start cycle, even if en_i=1.
  - SHIFT: on en_i=1, next shift register = {sr[WIDTH-2:0], x_i} and the counter increments. The first bit received ends up in word_o[WIDTH-1] (MSB-first).
  - SHIFT, en_i=1, counter=WIDTH-1 (completion): go to IDLE. The completed word is {sr[WIDTH-2:0], x_i}.
  - start_i in SHIFT is ignored; it neither restarts nor extends the frame.
- Bit counter width: $clog2(WIDTH). The counter never wraps mid-frame; it is cleared on start.
- Output buffer on completion:
  - If valid_o=0, or valid_o=1 and ready_i=1 in the same cycle: load word_o with the completed word and hold valid_o=1.
  - Otherwise (valid_o=1 and ready_i=0): discard the new word, keep word_o unchanged, and set ovf_o.
- Handshake:
  - A transfer occurs when valid_o=1 and ready_i=1 at a rising edge.
  - valid_o falls the next cycle unless a completion loads a new word in that same cycle.
  - ready_i while valid_o=0 has no effect.
- ovf_o is sticky and is cleared by clr_i=1. If an overrun and clr_i=1 occur in the same cycle, the set wins (ovf_o=1).
- busy_o = (state==SHIFT).

## Timing
- Reset values (reset=0 at a rising edge): state IDLE, counter 0, shift register 0, word_o 0, valid_o 0, busy_o 0, ovf_o 0. Reset mid-frame discards the partial frame and any buffered word.
- busy_o rises the cycle after start_i is accepted. It falls the cycle after the completion strobe.
- valid_o and word_o update the cycle after the completion strobe. Latency from the last bit sampled to valid_o is 1 cycle.
- Minimum frame time: 1 start cycle + WIDTH strobe cycles. The next start_i may be given in the first cycle after completion, when the block is back in IDLE.
- en_i gaps in SHIFT stall the frame indefinitely; there is no timeout.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: drive reset=0 for 2 cycles with random inputs, then release. Expect word_o=0, valid_o=0, busy_o=0, ovf_o=0. start_i is then accepted on the first cycle after release.
- Basic frame (WIDTH=4): start_i pulse, then en_i=1 for 4 consecutive cycles with x_i=1,0,1,1 and ready_i=0.
  - busy_o is high for 4 cycles.
  - valid_o=1 and word_o=4'hB the cycle after the 4th bit.
  - Raising ready_i drops valid_o next cycle.
- Gapped strobes and ignored restart: bits 0,1,1,0 with en_i low for 2 cycles between each bit, and start_i pulsed mid-frame.
  - Frame is unaffected; word_o=4'h6 after the 4th strobed bit.
  - x_i toggling during gaps is ignored.
- Backpressure and overrun: frame 4'hB is held with ready_i=0, then frame 4'h6 completes.
  - word_o stays 4'hB and ovf_o=1.
  - clr_i pulse clears ovf_o.
  - Repeating with clr_i asserted in the overrun cycle leaves ovf_o=1.
- Simultaneous accept and load: frame 4'hB is pending, and frame 4'h5 completes in the same cycle that ready_i=1.
  - valid_o stays 1, word_o becomes 4'h5, ovf_o stays 0.
- Reset mid-frame: after 2 of 4 bits, assert reset=0 for 1 cycle.
  - busy_o goes to 0.
  - A new frame of 1,1,1,0 yields exactly word_o=4'hE with no residue.

Source files
------------

// File: rtl/serial_frame_ctrl.sv
// Serial-in frame controller: a start pulse opens a frame, WIDTH gated strobes shift bits
// in MSB-first, and each completed word lands in a one-entry valid/ready buffer with overrun flag.
module serial_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             en_i,
  input  logic             x_i,
  input  logic             ready_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  // The top register bit would only ever be shifted out, so WIDTH-1 bits suffice.
  logic [WIDTH-2:0] sr_reg;
  logic [WIDTH-1:0] shift_next;
  logic             last_bit;

  assign shift_next = {sr_reg, x_i};
  assign last_bit   = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sr_reg    <= '0;
      word_o    <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      if (valid_o && ready_i)
        valid_o <= 1'b0;
      if (clr_i)
        ovf_o <= 1'b0;

      // A completing frame below overrides the transfer/clear defaults above.
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            state_reg <= SHIFT;
            busy_o    <= 1'b1;
            cnt_reg   <= '0;
            sr_reg    <= '0;
          end
        end
        SHIFT: begin
          if (en_i) begin
            sr_reg  <= shift_next[WIDTH-2:0];
            cnt_reg <= cnt_reg + CW'(1);
            if (last_bit) begin
              state_reg <= IDLE;
              busy_o    <= 1'b0;
              if (!valid_o || ready_i) begin
                word_o  <= shift_next;
                valid_o <= 1'b1;
              end else begin
                ovf_o <= 1'b1;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Bench for serial_frame_ctrl: directed scenarios plus random traffic, all checked every
// cycle against a bit-count/integer model of the framing rules.
module tb_serial_frame_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_i = 1'b0, en_i = 1'b0, x_i = 1'b0, ready_i = 1'b0, clr_i = 1'b0;
  logic [W-1:0] word_o;
  logic         valid_o, busy_o, ovf_o;

  int checks = 0;
  int errors = 0;

  serial_frame_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .en_i(en_i), .x_i(x_i),
    .ready_i(ready_i), .clr_i(clr_i), .word_o(word_o), .valid_o(valid_o),
    .busy_o(busy_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: frame progress as a count of received bits and an integer accumulator.
  bit m_started = 0;
  bit m_busy = 0;
  int m_nbits = 0;
  int m_acc = 0;
  bit m_valid = 0;
  int m_word = 0;
  bit m_ovf = 0;

  always @(posedge clk) begin
    bit nv, no;
    if (!reset) begin
      m_started = 1; m_busy = 0; m_nbits = 0; m_acc = 0;
      m_valid = 0; m_word = 0; m_ovf = 0;
    end else begin
      nv = m_valid && !ready_i;
      no = m_ovf && !clr_i;
      if (!m_busy) begin
        if (start_i) begin m_busy = 1; m_nbits = 0; m_acc = 0; end
      end else if (en_i) begin
        m_acc = (m_acc * 2 + int'(x_i)) % (1 << W);
        m_nbits++;
        if (m_nbits == W) begin
          m_busy = 0;
          if (!m_valid || ready_i) begin m_word = m_acc; nv = 1; end
          else no = 1;
        end
      end
      m_valid = nv;
      m_ovf = no;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("word_o", int'(word_o), m_word);
      chk("valid_o", int'(valid_o), int'(m_valid));
      chk("busy_o", int'(busy_o), int'(m_busy));
      chk("ovf_o", int'(ovf_o), int'(m_ovf));
    end
  end

  task automatic cyc(input bit s, input bit e, input bit x, input bit r, input bit c);
    @(negedge clk);
    reset = 1'b1; start_i = s; en_i = e; x_i = x; ready_i = r; clr_i = c;
  endtask

  task automatic rcyc();
    @(negedge clk);
    reset = 1'b0; start_i = 1'($urandom); en_i = 1'($urandom); x_i = 1'($urandom);
    ready_i = 1'($urandom); clr_i = 1'($urandom);
  endtask

  // Bits are sent MSB-first; ready/clr are raised only on the completing strobe.
  task automatic frame(input logic [W-1:0] bits, input int gap, input bit r_last, input bit c_last);
    cyc(1, 0, 1'($urandom), 0, 0);
    for (int i = W - 1; i >= 0; i--) begin
      for (int g = 0; g < gap; g++)
        cyc(g == 0 && i == 1, 0, 1'($urandom), 0, 0);
      cyc(0, 1, bits[i], (i == 0) && r_last, (i == 0) && c_last);
    end
  endtask

  initial begin
    rcyc(); rcyc();
    cyc(1, 0, 0, 0, 0);
    chk("reset word_o", int'(word_o), 0);
    chk("reset valid_o", int'(valid_o), 0);
    chk("reset busy_o", int'(busy_o), 0);
    chk("reset ovf_o", int'(ovf_o), 0);
    cyc(0, 1, 1, 0, 0);
    chk("start after reset busy", int'(busy_o), 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("basic valid", int'(valid_o), 1);
    chk("basic word", int'(word_o), 'hB);
    chk("basic busy low", int'(busy_o), 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("basic drained", int'(valid_o), 0);

    frame(4'b0110, 2, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("gapped word", int'(word_o), 'h6);
    chk("gapped valid", int'(valid_o), 1);
    cyc(0, 0, 0, 1, 0);

    frame(4'hB, 0, 0, 0);
    frame(4'h6, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("overrun word kept", int'(word_o), 'hB);
    chk("overrun ovf", int'(ovf_o), 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("clr ovf", int'(ovf_o), 0);
    frame(4'h6, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("set beats clr", int'(ovf_o), 1);
    chk("word still B", int'(word_o), 'hB);
    cyc(0, 0, 0, 1, 1);

    frame(4'hB, 0, 0, 0);
    frame(4'h5, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("simul valid", int'(valid_o), 1);
    chk("simul word", int'(word_o), 'h5);
    chk("simul ovf", int'(ovf_o), 0);
    cyc(0, 0, 0, 1, 0);

    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0; start_i = 0; en_i = 1; x_i = 1; ready_i = 0; clr_i = 0;
    cyc(0, 0, 0, 0, 0);
    chk("midreset busy", int'(busy_o), 0);
    chk("midreset valid", int'(valid_o), 0);
    frame(4'hE, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("after reset word", int'(word_o), 'hE);
    cyc(0, 0, 0, 1, 0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 299) != 0);
      start_i = ($urandom_range(0, 3) == 0);
      en_i    = ($urandom_range(0, 2) != 0);
      x_i     = 1'($urandom);
      ready_i = ($urandom_range(0, 3) == 0);
      clr_i   = ($urandom_range(0, 9) == 0);
    end
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
